// File: rtl/mesi_snooper.sv
// Four-line MESI snoop responder: accepts bus snoops, flushes Modified lines
// to memory when required, then reports sharing and applies the new line state.
module mesi_snooper (
    input  logic       clock,
    input  logic       resetn,
    input  logic       bus_valid,
    input  logic [1:0] bus_cmd,
    input  logic [1:0] bus_idx,
    output logic       bus_ready,
    input  logic       set_en,
    input  logic [1:0] set_idx,
    input  logic [1:0] set_state,
    output logic       resp_valid,
    output logic       resp_shared,
    output logic       mem_valid,
    output logic [1:0] mem_cmd,
    output logic [1:0] mem_idx,
    input  logic       mem_ack,
    output logic       err,
    input  logic [1:0] mon_idx,
    output logic [1:0] mon_state
);

    localparam logic [1:0] ST_I = 2'b00;
    localparam logic [1:0] ST_S = 2'b01;
    localparam logic [1:0] ST_M = 2'b11;

    localparam logic [1:0] CMD_NONE = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_UPGR = 2'b11;

    typedef enum logic [1:0] {IDLE, LOOKUP, FLUSH, RESP} fsm_t;

    fsm_t       state_reg, state_next;
    logic [1:0] cmd_reg, cmd_next;
    logic [1:0] idx_reg, idx_next;
    logic [1:0] pre_reg, pre_next;
    logic [1:0] new_reg, new_next;
    logic       err_reg, err_next;
    logic       snoop_wr;
    logic [1:0] looked;

    logic [1:0] line_reg  [4];
    logic [1:0] line_next [4];

    assign looked    = line_reg[idx_reg];
    assign mon_state = line_reg[mon_idx];
    assign err       = err_reg;

    always_comb begin
        state_next  = state_reg;
        cmd_next    = cmd_reg;
        idx_next    = idx_reg;
        pre_next    = pre_reg;
        new_next    = new_reg;
        err_next    = err_reg;
        snoop_wr    = 1'b0;
        bus_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_shared = 1'b0;
        mem_valid   = 1'b0;
        mem_cmd     = 2'b00;
        mem_idx     = 2'b00;
        case (state_reg)
            IDLE: begin
                bus_ready = 1'b1;
                if (bus_valid && bus_cmd != CMD_NONE) begin
                    cmd_next   = bus_cmd;
                    idx_next   = bus_idx;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                pre_next = looked;
                // Only a read of a valid line leaves a copy behind; everything else invalidates.
                new_next = (cmd_reg == CMD_RD && looked != ST_I) ? ST_S : ST_I;
                if (looked == ST_M && cmd_reg != CMD_UPGR) begin
                    state_next = FLUSH;
                end else begin
                    state_next = RESP;
                end
                if (looked == ST_M && cmd_reg == CMD_UPGR) begin
                    err_next = 1'b1;
                end
            end
            FLUSH: begin
                mem_valid = 1'b1;
                mem_cmd   = 2'b01;
                mem_idx   = idx_reg;
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid  = 1'b1;
                resp_shared = (pre_reg != ST_I);
                snoop_wr    = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-line update: the snoop owns its captured line while the FSM is busy.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            always_comb begin
                line_next[gi] = line_reg[gi];
                if (snoop_wr && idx_reg == 2'(gi)) begin
                    line_next[gi] = new_reg;
                end else if (set_en && set_idx == 2'(gi) &&
                             !(state_reg != IDLE && idx_reg == 2'(gi))) begin
                    line_next[gi] = set_state;
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cmd_reg   <= 2'b00;
            idx_reg   <= 2'b00;
            pre_reg   <= 2'b00;
            new_reg   <= 2'b00;
            err_reg   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                line_reg[i] <= ST_I;
            end
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            idx_reg   <= idx_next;
            pre_reg   <= pre_next;
            new_reg   <= new_next;
            err_reg   <= err_next;
            for (int i = 0; i < 4; i++) begin
                line_reg[i] <= line_next[i];
            end
        end
    end

endmodule

// File: tb/tb_mesi_snooper.sv
// Randomized and directed bench for mesi_snooper: a scoreboard queue of
// expected responses is checked by an independent monitor.
module tb_mesi_snooper;

    logic       clock = 1'b0;
    logic       resetn;
    logic       bus_valid;
    logic [1:0] bus_cmd;
    logic [1:0] bus_idx;
    logic       bus_ready;
    logic       set_en;
    logic [1:0] set_idx;
    logic [1:0] set_state;
    logic       resp_valid;
    logic       resp_shared;
    logic       mem_valid;
    logic [1:0] mem_cmd;
    logic [1:0] mem_idx;
    logic       mem_ack;
    logic       err;
    logic [1:0] mon_idx;
    logic [1:0] mon_state;

    always #5 clock = ~clock;

    mesi_snooper dut (
        .clock      (clock),
        .resetn     (resetn),
        .bus_valid  (bus_valid),
        .bus_cmd    (bus_cmd),
        .bus_idx    (bus_idx),
        .bus_ready  (bus_ready),
        .set_en     (set_en),
        .set_idx    (set_idx),
        .set_state  (set_state),
        .resp_valid (resp_valid),
        .resp_shared(resp_shared),
        .mem_valid  (mem_valid),
        .mem_cmd    (mem_cmd),
        .mem_idx    (mem_idx),
        .mem_ack    (mem_ack),
        .err        (err),
        .mon_idx    (mon_idx),
        .mon_state  (mon_state)
    );

    typedef struct {
        logic       shared;
        logic       flush;
        logic [1:0] idx;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] model_lines [4];
    logic       model_err;
    bit         flush_seen;
    int         n_pass   = 0;
    int         n_checks = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Monitor: pops one expectation per response pulse.
    always @(negedge clock) begin
        if (resetn) begin
            if (mem_valid) begin
                if (exp_q.size() == 0) begin
                    chk("mem_unexpected", 1, 0);
                end else begin
                    chk("mem_cmd", int'(mem_cmd), 1);
                    chk("mem_idx", int'(mem_idx), int'(exp_q[0].idx));
                    flush_seen = 1'b1;
                end
            end
            if (resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_shared", int'(resp_shared), int'(e.shared));
                    chk("flush_before_resp", int'(flush_seen), int'(e.flush));
                    chk("mem_quiet_in_resp", int'({mem_valid, mem_cmd, mem_idx}), 0);
                    $display("resp idx=%0d shared=%0d flush=%0d", e.idx, resp_shared, flush_seen);
                    flush_seen = 1'b0;
                end
            end
        end
    end

    task automatic set_line(input logic [1:0] idx, input logic [1:0] st);
        @(negedge clock);
        set_en = 1'b1; set_idx = idx; set_state = st;
        @(posedge clock); #1;
        set_en = 1'b0;
        model_lines[idx] = st;
        $display("set line%0d=%0d", idx, st);
    endtask

    task automatic null_hs(input logic [1:0] idx);
        @(negedge clock);
        bus_valid = 1'b1; bus_cmd = 2'b00; bus_idx = idx;
        @(posedge clock); #1;
        bus_valid = 1'b0;
        @(negedge clock);
        chk("null_hs_ready", int'(bus_ready), 1);
        $display("null handshake idx=%0d", idx);
    endtask

    task automatic snoop(input logic [1:0] cmd, input logic [1:0] idx, input int d,
                         input bit same_set, input logic [1:0] ss_state,
                         input bit mid_set, input logic [1:0] ms_idx,
                         input logic [1:0] ms_state, input bit spur);
        exp_t       e;
        logic [1:0] pre;
        bit         fl;
        int         resp_at;
        int         mv_cnt;
        @(negedge clock);
        chk("ready_before_snoop", int'(bus_ready), 1);
        bus_valid = 1'b1; bus_cmd = cmd; bus_idx = idx;
        if (same_set) begin
            set_en = 1'b1; set_idx = idx; set_state = ss_state;
        end
        @(posedge clock); #1;
        bus_valid = 1'b0; bus_cmd = 2'b00; set_en = 1'b0;
        if (same_set) model_lines[idx] = ss_state;
        pre = model_lines[idx];
        fl  = (pre == 2'b11) && (cmd != 2'b11);
        e.shared = (pre != 2'b00); e.flush = fl; e.idx = idx;
        exp_q.push_back(e);
        if (cmd == 2'b11 && pre == 2'b11) model_err = 1'b1;
        model_lines[idx] = (cmd == 2'b01 && pre != 2'b00) ? 2'b01 : 2'b00;
        resp_at = 0;
        mv_cnt  = 0;
        for (int k = 1; k <= 40 && resp_at == 0; k++) begin
            @(negedge clock);
            if (k == 1 && mid_set) begin
                set_en = 1'b1; set_idx = ms_idx; set_state = ms_state;
                if (ms_idx != idx) model_lines[ms_idx] = ms_state;
            end
            if (k == 1 && spur) mem_ack = 1'b1;
            if (mem_valid) begin
                mv_cnt++;
                if (mv_cnt == d) mem_ack = 1'b1;
            end
            if (resp_valid) resp_at = k;
            @(posedge clock); #1;
            set_en = 1'b0; mem_ack = 1'b0;
        end
        chk("resp_latency", resp_at, fl ? 2 + d : 2);
        chk("flush_cycles", mv_cnt, fl ? d : 0);
        @(negedge clock);
        chk("ready_after_snoop", int'(bus_ready), 1);
        mon_idx = idx;
        #1;
        chk("line_after_snoop", int'(mon_state), int'(model_lines[idx]));
        chk("err_after_snoop", int'(err), int'(model_err));
        $display("snoop cmd=%0d idx=%0d pre=%0d new=%0d lat=%0d", cmd, idx, pre, model_lines[idx], resp_at);
    endtask

    task automatic check_all_lines(input string name);
        for (int i = 0; i < 4; i++) begin
            mon_idx = 2'(i);
            #1;
            chk(name, int'(mon_state), int'(model_lines[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; bus_valid = 1'b0; bus_cmd = 2'b00; bus_idx = 2'b00;
        set_en = 1'b0; set_idx = 2'b00; set_state = 2'b00; mem_ack = 1'b0; mon_idx = 2'b00;
        for (int i = 0; i < 4; i++) model_lines[i] = 2'b00;
        model_err = 1'b0; flush_seen = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_bus_ready", int'(bus_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_mem", int'({mem_valid, mem_cmd, mem_idx}), 0);
        chk("rst_err", int'(err), 0);
        check_all_lines("rst_line");
        @(negedge clock);
        resetn = 1'b1;

        // Directed scenarios
        set_line(2'd1, 2'b10);
        snoop(2'b01, 2'd1, 1, 0, 2'b00, 0, 2'd0, 2'b00, 0);
        set_line(2'd2, 2'b11);
        snoop(2'b10, 2'd2, 3, 0, 2'b00, 0, 2'd0, 2'b00, 1);
        snoop(2'b01, 2'd3, 1, 0, 2'b00, 0, 2'd0, 2'b00, 0);
        set_line(2'd0, 2'b11);
        snoop(2'b11, 2'd0, 1, 0, 2'b00, 0, 2'd0, 2'b00, 0);
        snoop(2'b01, 2'd3, 1, 0, 2'b00, 0, 2'd0, 2'b00, 0);
        set_line(2'd1, 2'b01);
        snoop(2'b10, 2'd1, 1, 0, 2'b00, 1, 2'd1, 2'b11, 0);
        snoop(2'b01, 2'd2, 1, 1, 2'b10, 0, 2'd0, 2'b00, 0);
        null_hs(2'd2);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                set_line(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            end else if (r == 3) begin
                null_hs(2'($urandom_range(0, 3)));
            end else begin
                snoop(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)), $urandom_range(1, 4),
                      $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
                      $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 1) == 1);
            end
        end
        check_all_lines("random_final_line");

        // Reset in the middle of a flush
        set_line(2'd3, 2'b11);
        @(negedge clock);
        bus_valid = 1'b1; bus_cmd = 2'b01; bus_idx = 2'd3;
        @(posedge clock); #1;
        bus_valid = 1'b0; bus_cmd = 2'b00;
        e_push_flush();
        begin
            int w;
            w = 0;
            while (!mem_valid && w < 10) begin
                @(negedge clock);
                w++;
            end
            chk("flush_reached", int'(mem_valid), 1);
        end
        @(negedge clock);
        #2;
        resetn = 1'b0;
        #1;
        exp_q.delete();
        flush_seen = 1'b0;
        for (int i = 0; i < 4; i++) model_lines[i] = 2'b00;
        model_err = 1'b0;
        chk("rst_flush_mem_valid", int'(mem_valid), 0);
        chk("rst_flush_mem_bus", int'({mem_cmd, mem_idx}), 0);
        chk("rst_flush_ready", int'(bus_ready), 1);
        chk("rst_flush_err", int'(err), 0);
        check_all_lines("rst_flush_line");
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
        snoop(2'b01, 2'd3, 1, 0, 2'b00, 0, 2'd0, 2'b00, 0);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    task automatic e_push_flush();
        exp_t e;
        e.shared = 1'b1; e.flush = 1'b1; e.idx = 2'd3;
        exp_q.push_back(e);
    endtask

endmodule
